mem_copy_dma: RTL and testbench
===============================

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 Parameter ADDR_WIDTH, default 15; byte-address width of the memory port, matching a 2**13-word RAM.
REQ-002 Parameter LEN_WIDTH, default 13; width of the word-count input.
REQ-003 Port clk, input, 1; the only clock. All state changes on its rising edge.
REQ-004 Port rst, input, 1; synchronous, active-high reset.
REQ-005 Port start, input, 1; transfer request, sampled only in IDLE.
REQ-006 Port src_addr, input, ADDR_WIDTH; source byte address. Bits [1:0] are ignored and treated as 0.
REQ-007 Port dst_addr, input, ADDR_WIDTH; destination byte address. Bits [1:0] are ignored and treated as 0.
REQ-008 Port len_words, input, LEN_WIDTH; number of 32-bit words to copy.
REQ-009 Port busy, output, 1; high in READ and WRITE.
REQ-010 Port done, output, 1; one-cycle completion pulse.
REQ-011 Port mem_addr, output, ADDR_WIDTH; byte address to the RAM port. Bits [1:0] are always 0.
REQ-012 Port mem_wdata, output, 32; write data to the RAM port.
REQ-013 Port mem_wenable, output, 4; per-byte write enables to the RAM port.
REQ-014 Port mem_rdata, input, 32; read data from the RAM port. It is valid combinationally for the current mem_addr.

Function
REQ-015 States: IDLE, READ, WRITE, DONE. Encoding is free.
REQ-016 IDLE with start=1: latch src_addr&~3 into src_ptr, dst_addr&~3 into dst_ptr, and len_words into remaining.
- Next state is READ if len_words != 0, otherwise DONE.
REQ-017 READ: mem_addr=src_ptr, mem_wenable=0. At the clock edge, buffer<=mem_rdata and the state moves to WRITE.
REQ-018 WRITE: mem_addr=dst_ptr, mem_wdata=buffer, mem_wenable=4'hF.
- At the edge: src_ptr+=4, dst_ptr+=4, remaining-=1.
- Next state is DONE if remaining was 1, otherwise READ.
REQ-019 DONE: done=1 for exactly one cycle, then IDLE.
REQ-020 Outside WRITE, mem_wenable=0. In IDLE and DONE, mem_addr=0 and mem_wdata=0.
REQ-021 Latency: an N-word copy (N>0) is busy for exactly 2N cycles. done is asserted in cycle 2N+1 after the start edge.
REQ-022 Pointer arithmetic is modulo 2**ADDR_WIDTH; addresses wrap past the top of memory to 0 silently.
REQ-023 start while busy or in DONE is ignored. src_addr, dst_addr and len_words may change after the start edge without effect.
REQ-024 Overlapping regions: the copy proceeds in ascending address order, one word at a time, with no overlap correction.

Reset
REQ-025 rst=1 at any edge forces IDLE.
- busy=0, done=0, mem_wenable=0, mem_addr=0, mem_wdata=0.
- src_ptr, dst_ptr, remaining and buffer all reset to 0.
REQ-026 Reset mid-transfer aborts immediately: no further write is issued after the reset edge. Words already written stay written.

Configuration
REQ-027 Macro DMA_FILL_EN.
- When defined: extra ports fill (input, 1) and fill_pattern (input, 32) are present.
- start with fill=1 latches fill_pattern and skips READ entirely: WRITE repeats every cycle with mem_wdata=pattern.
- In fill mode, an N-word fill is busy for N cycles and done is asserted at cycle N+1.
- When undefined: the fill and fill_pattern ports do not exist and only copy mode is built.

Verification
REQ-028 Copy: RAM words 0x10..0x1C preloaded with 0xA0..0xA3; start with src=0x10, dst=0x40, len=4.
- Required: RAM 0x40..0x4C = 0xA0..0xA3.
- busy is high for 8 cycles and done pulses once in cycle 9.
REQ-029 Zero length: start with len=0.
- Required: busy never rises, done pulses in the cycle after the start edge, mem_wenable stays 0.
REQ-030 Unaligned addresses and wrap: src=0x13, dst=0x7FFE, len=2, ADDR_WIDTH=15.
- Required: reads at 0x10 and 0x14; writes at 0x7FFC and then 0x0000.
REQ-031 Ignored start, then abort: start is re-pulsed in cycle 3 of a 4-word copy and has no effect; rst is asserted in cycle 5.
- Required: exactly 2 words are written, then IDLE with all outputs 0.
- A new start after reset runs normally.
REQ-032 DMA_FILL_EN defined: fill=1, pattern=0xDEADBEEF, dst=0x100, len=3.
- Required: 0x100..0x108 all equal 0xDEADBEEF.
- busy is high for 3 cycles and there are no read-only cycles.

Source files
------------

// File: rtl/mem_copy_dma.sv
// Word-granular memory-to-memory copy engine on a single RAM port.
// Optional DMA_FILL_EN macro adds a pattern-fill mode (no read phase).
module mem_copy_dma #(
  parameter int ADDR_WIDTH = 15,
  parameter int LEN_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len_words,
`ifdef DMA_FILL_EN
  input  logic                  fill,
  input  logic [31:0]           fill_pattern,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wenable,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ALIGN =
    {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(4);
  localparam logic [LEN_WIDTH-1:0]  ONE  = LEN_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [31:0]           buffer_q, buffer_d;
  logic                  fill_mode;

`ifdef DMA_FILL_EN
  logic fill_q, fill_d;
  assign fill_mode = fill_q;
`else
  assign fill_mode = 1'b0;
`endif

  // State and datapath registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      buffer_q    <= '0;
`ifdef DMA_FILL_EN
      fill_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      buffer_q    <= buffer_d;
`ifdef DMA_FILL_EN
      fill_q      <= fill_d;
`endif
    end
  end

  // Next-state: copy alternates READ/WRITE, fill stays in WRITE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_words == '0) begin
            state_d = S_DONE;
`ifdef DMA_FILL_EN
          end else if (fill) begin
            state_d = S_WRITE;
`endif
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ:  state_d = S_WRITE;
      S_WRITE: begin
        if (remaining_q == ONE) begin
          state_d = S_DONE;
        end else if (fill_mode) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: latch on start, capture on read, advance on write
  always_comb begin
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    buffer_d    = buffer_q;
`ifdef DMA_FILL_EN
    fill_d      = fill_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_ptr_d   = src_addr & ALIGN;
          dst_ptr_d   = dst_addr & ALIGN;
          remaining_d = len_words;
`ifdef DMA_FILL_EN
          fill_d      = fill;
          if (fill) begin
            buffer_d = fill_pattern;
          end
`endif
        end
      end
      S_READ: begin
        buffer_d = mem_rdata;
      end
      S_WRITE: begin
        src_ptr_d   = src_ptr_q + STEP;
        dst_ptr_d   = dst_ptr_q + STEP;
        remaining_d = remaining_q - ONE;
      end
      default: begin
        buffer_d = buffer_q;
      end
    endcase
  end

  // Memory port and status outputs decoded from the current state
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wenable = 4'h0;
    unique case (state_q)
      S_READ: begin
        busy     = 1'b1;
        mem_addr = src_ptr_q;
      end
      S_WRITE: begin
        busy        = 1'b1;
        mem_addr    = dst_ptr_q;
        mem_wdata   = buffer_q;
        mem_wenable = 4'hF;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Randomised scoreboard bench for mem_copy_dma with a word-level RAM model.
// Fill-mode case is built only when DMA_FILL_EN is defined.
module tb_mem_copy_dma;

  localparam int AW    = 15;
  localparam int LW    = 13;
  localparam int WORDS = 8192;

  typedef struct {
    bit          wr;
    logic [14:0] addr;
    logic [31:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [LW-1:0] len_words;
`ifdef DMA_FILL_EN
  logic          fill;
  logic [31:0]   fill_pattern;
`endif
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wenable;
  logic [31:0]   mem_rdata;

  logic [31:0] ram  [WORDS];
  logic [31:0] refm [WORDS];
  logic [31:0] seed;
  logic        ram_init;
  ev_t         exp_q [$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  mem_copy_dma #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .len_words   (len_words),
`ifdef DMA_FILL_EN
    .fill        (fill),
    .fill_pattern(fill_pattern),
`endif
    .busy        (busy),
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wenable (mem_wenable),
    .mem_rdata   (mem_rdata)
  );

  function automatic logic [31:0] word_init(int i);
    if (i >= 4 && i < 8) return 32'hA0 + 32'(i - 4);
    return (32'(i) * 32'h9E3779B1) ^ seed;
  endfunction

  assign mem_rdata = ram[mem_addr[AW-1:2]];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= word_init(i);
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_wenable[b])
          ram[mem_addr[AW-1:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: every busy cycle must match the next expected bus event
  always @(negedge clk) begin
    ev_t ev;
    if (busy === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_bus actual=addr %h wen %h required=no activity",
                 mem_addr, mem_wenable);
      end else begin
        ev = exp_q.pop_front();
        chk("bus_addr", 32'(mem_addr), 32'(ev.addr));
        chk("bus_wen", 32'(mem_wenable), ev.wr ? 32'hF : 32'h0);
        if (ev.wr) chk("bus_wdata", mem_wdata, ev.data);
      end
    end else if (ram_init === 1'b0) begin
      chk("idle_wen", 32'(mem_wenable), 32'h0);
      chk("idle_addr", 32'(mem_addr), 32'h0);
      chk("idle_wdata", mem_wdata, 32'h0);
    end
  end

  // Reference model: ascending word copy over a flat word array
  task automatic model_copy(logic [AW-1:0] s, logic [AW-1:0] d, int n);
    int si, di;
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      si = (int'(s) / 4 + i) % WORDS;
      di = (int'(d) / 4 + i) % WORDS;
      w = refm[si];
      exp_q.push_back('{wr: 1'b0, addr: 15'(si * 4), data: 32'h0});
      refm[di] = w;
      exp_q.push_back('{wr: 1'b1, addr: 15'(di * 4), data: w});
    end
  endtask

  task automatic model_fill(logic [AW-1:0] d, int n, logic [31:0] p);
    int di;
    for (int i = 0; i < n; i++) begin
      di = (int'(d) / 4 + i) % WORDS;
      refm[di] = p;
      exp_q.push_back('{wr: 1'b1, addr: 15'(di * 4), data: p});
    end
  endtask

  task automatic check_ram(string nm);
    int mism = 0;
    for (int i = 0; i < WORDS; i++)
      if (ram[i] !== refm[i]) mism++;
    chk(nm, 32'(mism), 32'h0);
  endtask

  task automatic wait_done(string nm, int exp_busy, int exp_done);
    int bcnt = 0;
    int dat  = 0;
    for (int c = 1; c <= 4 * exp_done + 8; c++) begin
      @(negedge clk);
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) begin
        dat = c;
        break;
      end
    end
    chk({nm, "_busy_cycles"}, 32'(bcnt), 32'(exp_busy));
    chk({nm, "_done_cycle"}, 32'(dat), 32'(exp_done));
    @(negedge clk);
    chk({nm, "_done_single"}, 32'(done), 32'h0);
    chk({nm, "_queue_drained"}, 32'(exp_q.size()), 32'h0);
    check_ram({nm, "_ram"});
  endtask

  task automatic pulse_start(logic [AW-1:0] s, logic [AW-1:0] d,
                             int n, bit f);
    @(negedge clk);
    src_addr  = s;
    dst_addr  = d;
    len_words = LW'(n);
`ifdef DMA_FILL_EN
    fill = f;
`else
    if (f) $display("fill requested without fill build");
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    src_addr  = AW'($urandom);
    dst_addr  = AW'($urandom);
    len_words = LW'($urandom);
`ifdef DMA_FILL_EN
    fill = 1'b0;
`endif
  endtask

  task automatic run_copy(string nm, logic [AW-1:0] s,
                          logic [AW-1:0] d, int n);
    model_copy(s, d, n);
    pulse_start(s, d, n, 1'b0);
    wait_done(nm, 2 * n, 2 * n + 1);
  endtask

  initial begin
    logic [AW-1:0] s, d;
    int            n;
    seed      = $urandom;
    ram_init  = 1'b1;
    rst       = 1'b1;
    start     = 1'b0;
    src_addr  = '0;
    dst_addr  = '0;
    len_words = '0;
`ifdef DMA_FILL_EN
    fill         = 1'b0;
    fill_pattern = 32'h0;
`endif
    for (int i = 0; i < WORDS; i++) refm[i] = word_init(i);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_wen", 32'(mem_wenable), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    ram_init = 1'b0;
    rst      = 1'b0;

    run_copy("basic", 15'h0010, 15'h0040, 4);
    for (int i = 0; i < 4; i++)
      chk("basic_dst_word", ram[16 + i], 32'hA0 + 32'(i));

    run_copy("zero_len", 15'h0123, 15'h0456, 0);

    run_copy("wrap", 15'h0013, 15'h7FFE, 2);

    run_copy("overlap", 15'h0200, 15'h0204, 5);

    // Abort: re-pulse start in cycle 3, reset in cycle 5
    model_copy(15'h0300, 15'h0400, 2);
    exp_q.push_back('{wr: 1'b0, addr: 15'h0308, data: 32'h0});
    pulse_start(15'h0300, 15'h0400, 4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    start     = 1'b1;
    src_addr  = 15'h0600;
    len_words = LW'(7);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_wen", 32'(mem_wenable), 32'h0);
    chk("abort_addr", 32'(mem_addr), 32'h0);
    chk("abort_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_queue", 32'(exp_q.size()), 32'h0);
    check_ram("abort_ram");
    run_copy("after_abort", 15'h0300, 15'h0500, 3);

`ifdef DMA_FILL_EN
    fill_pattern = 32'hDEADBEEF;
    model_fill(15'h0100, 3, 32'hDEADBEEF);
    pulse_start(15'h0100, 15'h0100, 3, 1'b1);
    wait_done("fill", 3, 4);
`endif

    for (int t = 0; t < 15; t++) begin
      s = AW'($urandom);
      d = AW'($urandom);
      n = int'($urandom_range(1, 8));
      run_copy("random", s, d, n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
